add16_seq_arb: RTL and testbench

Sequential 16-bit adder controller that time-shares one `sum_4b` carry-lookahead slice between two requesters. It arbitrates round-robin, captures the winner's operands, and steps the slice over four nibbles, low nibble first. A carry register and a group P/G accumulator run alongside, and the full 16-bit result, carry-out, signed overflow and 16-bit group propagate/generate are committed with a one-cycle `done`. It sits beside the `sum_16b` datapath as its area-reduced, multi-cycle alternative.

---
 rtl/add16_seq_arb.sv | 173 +++++++++++++++++
 tb/tb_add16_seq_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/add16_seq_arb.sv
// add16_seq_arb: round-robin shared 4-bit CLA slice stepped over four nibbles to form a 16-bit add
module sum_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_in_i,
  output logic [3:0] s_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] p, g;
  logic [3:0] c;
  assign p = a_i ^ b_i;
  assign g = a_i & b_i;
  assign c[0] = c_in_i;
  assign c[1] = g[0] | (p[0] & c_in_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in_i);
  assign s_o = p ^ c;
  assign p_o = &p;
  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module add16_seq_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [15:0] a0_i,
  input  logic [15:0] b0_i,
  input  logic [15:0] a1_i,
  input  logic [15:0] b1_i,
  input  logic        cin0_i,
  input  logic        cin1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        done_id_o,
  output logic [15:0] sum_o,
  output logic        cout_o,
  output logic        ovf_o,
  output logic        p_all_o,
  output logic        g_all_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
  logic        c_q, c_d, id_q, id_d, last_q, last_d, p_acc_q, p_acc_d, g_acc_q, g_acc_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d, done_q, done_d, done_id_q, done_id_d;
  logic        cout_q, cout_d, ovf_q, ovf_d, p_all_q, p_all_d, g_all_q, g_all_d;
  logic [3:0]  s;
  logic        sp, sg, c_next, grant0, grant1;
  sum_4b u_slice (
    .a_i    (a_q[{k_q, 2'b00} +: 4]),
    .b_i    (b_q[{k_q, 2'b00} +: 4]),
    .c_in_i (c_q),
    .s_o    (s),
    .p_o    (sp),
    .g_o    (sg)
  );
  assign c_next = sg | (sp & c_q);
  // last_q==1 means requester 1 was served last, so requester 0 wins a tie
  assign grant0 = req0_i & (~req1_i | last_q);
  assign grant1 = req1_i & ~grant0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      sum_q     <= '0;
      c_q       <= 1'b0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      p_acc_q   <= 1'b0;
      g_acc_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      p_all_q   <= 1'b0;
      g_all_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      sum_q     <= sum_d;
      c_q       <= c_d;
      id_q      <= id_d;
      last_q    <= last_d;
      p_acc_q   <= p_acc_d;
      g_acc_q   <= g_acc_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      p_all_q   <= p_all_d;
      g_all_q   <= g_all_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    sum_d     = sum_q;
    c_d       = c_q;
    id_d      = id_q;
    last_d    = last_q;
    p_acc_d   = p_acc_q;
    g_acc_d   = g_acc_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    p_all_d   = p_all_q;
    g_all_d   = g_all_q;
    case (state_q)
      IDLE: if (grant0 | grant1) begin
        state_d = RUN;
        a_d     = grant1 ? a1_i : a0_i;
        b_d     = grant1 ? b1_i : b0_i;
        c_d     = grant1 ? cin1_i : cin0_i;
        id_d    = grant1;
        last_d  = grant1;
        gnt0_d  = grant0;
        gnt1_d  = grant1;
        k_d     = 2'd0;
        p_acc_d = 1'b1;
        g_acc_d = 1'b0;
      end
      RUN: begin
        work_d[{k_q, 2'b00} +: 4] = s;
        c_d     = c_next;
        p_acc_d = sp & p_acc_q;
        g_acc_d = sg | (sp & g_acc_q);
        k_d     = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d   = DONE;
          sum_d     = {s, work_q[11:0]};
          cout_d    = c_next;
          p_all_d   = sp & p_acc_q;
          g_all_d   = sg | (sp & g_acc_q);
          ovf_d     = (a_q[15] == b_q[15]) && (s[3] != a_q[15]);
          done_id_d = id_q;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign busy_o    = state_q != IDLE;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign ovf_o     = ovf_q;
  assign p_all_o   = p_all_q;
  assign g_all_o   = g_all_q;
endmodule

// File: tb/tb_add16_seq_arb.sv
// tb_add16_seq_arb: directed self-checking bench for add16_seq_arb
module tb_add16_seq_arb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, busy, done, done_id, cout, ovf, p_all, g_all;
  logic [15:0] sum;
  int          n_cmp = 0, n_err = 0;
  bit          ok;

  add16_seq_arb dut (
    .clk(clk), .rst_n(rst_n), .req0_i(req0), .req1_i(req1),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .cin0_i(cin0), .cin1_i(cin1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .busy_o(busy), .done_o(done), .done_id_o(done_id),
    .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .p_all_o(p_all), .g_all_o(g_all)
  );

  always #5 clk = ~clk;

  // sel: 0 gnt0, 1 gnt1, 2 done, 3 either grant; bounded at 20 cycles
  task automatic wait_for(input int sel, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sel == 0 ? gnt0 : sel == 1 ? gnt1 : sel == 2 ? done : (gnt0 | gnt1)) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({sum, cout, ovf, p_all, g_all, gnt0, gnt1, busy, done, done_id} !== 25'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", {sum, cout, ovf, p_all, g_all, gnt0, gnt1, busy, done, done_id});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if ({sum, cout, ovf, p_all, g_all, gnt0, gnt1, busy, done, done_id} !== 25'd0) begin
      n_err++; $display("FAIL idle_after_release got=%h want=0", {sum, cout, ovf, p_all, g_all, gnt0, gnt1, busy, done, done_id});
    end
  endtask

  task automatic test_single_req0();
    a0 = 16'h8000; b0 = 16'h8000; cin0 = 1'b0; req0 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({gnt0, gnt1, busy} !== 3'b101) begin
      n_err++; $display("FAIL single_gnt got=%b want=101", {gnt0, gnt1, busy});
    end
    req0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if ({done, busy, sum} !== {2'b01, 16'h0000}) begin
      n_err++; $display("FAIL single_early_done got=%h want=%h", {done, busy, sum}, {2'b01, 16'h0000});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, sum, cout, ovf, p_all, g_all, done_id} !== {1'b1, 16'h0000, 5'b11010}) begin
      n_err++; $display("FAIL single_result got=%h want=%h", {done, sum, cout, ovf, p_all, g_all, done_id}, {1'b1, 16'h0000, 5'b11010});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL single_done_pulse got=%b want=00", {done, busy});
    end
  endtask

  task automatic test_req1_carry();
    a1 = 16'hFFFF; b1 = 16'h0000; cin1 = 1'b1; req1 = 1'b1;
    wait_for(1, ok);
    req1 = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL req1_gnt got=timeout want=gnt1"); end
    wait_for(2, ok);
    n_cmp++;
    if ({ok, sum, cout, ovf, p_all, g_all, done_id} !== {1'b1, 16'h0000, 5'b10101}) begin
      n_err++; $display("FAIL req1_result got=%h want=%h", {ok, sum, cout, ovf, p_all, g_all, done_id}, {1'b1, 16'h0000, 5'b10101});
    end
  endtask

  task automatic test_tie();
    a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b0;
    a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    wait_for(3, ok);
    n_cmp++;
    if ({ok, gnt0, gnt1} !== 3'b110) begin
      n_err++; $display("FAIL tie1_winner got=%b want=110", {ok, gnt0, gnt1});
    end
    req0 = 1'b0;
    wait_for(2, ok);
    n_cmp++;
    if ({ok, sum, cout, ovf, p_all, g_all, done_id} !== {1'b1, 16'h5555, 5'b00000}) begin
      n_err++; $display("FAIL tie1_result got=%h want=%h", {ok, sum, cout, ovf, p_all, g_all, done_id}, {1'b1, 16'h5555, 5'b00000});
    end
    wait_for(3, ok);
    n_cmp++;
    if ({ok, gnt0, gnt1} !== 3'b101) begin
      n_err++; $display("FAIL tie2_winner got=%b want=101", {ok, gnt0, gnt1});
    end
    req1 = 1'b0;
    wait_for(2, ok);
    n_cmp++;
    if ({ok, sum, cout, ovf, p_all, g_all, done_id} !== {1'b1, 16'h8000, 5'b01001}) begin
      n_err++; $display("FAIL tie2_result got=%h want=%h", {ok, sum, cout, ovf, p_all, g_all, done_id}, {1'b1, 16'h8000, 5'b01001});
    end
    a0 = 16'h0001; b0 = 16'h0002;
    req0 = 1'b1; req1 = 1'b1;
    wait_for(3, ok);
    n_cmp++;
    if ({ok, gnt0, gnt1} !== 3'b110) begin
      n_err++; $display("FAIL tie3_winner got=%b want=110", {ok, gnt0, gnt1});
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_for(2, ok);
    n_cmp++;
    if ({ok, sum, done_id} !== {1'b1, 16'h0003, 1'b0}) begin
      n_err++; $display("FAIL tie3_result got=%h want=%h", {ok, sum, done_id}, {1'b1, 16'h0003, 1'b0});
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0; req0 = 1'b1;
    wait_for(0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL midrst_gnt got=timeout want=gnt0"); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({sum, cout, ovf, p_all, g_all, gnt0, gnt1, busy, done, done_id} !== 25'd0) begin
      n_err++; $display("FAIL midrst_outputs got=%h want=0", {sum, cout, ovf, p_all, g_all, gnt0, gnt1, busy, done, done_id});
    end
    @(negedge clk); rst_n = 1'b1;
    wait_for(0, ok);
    req0 = 1'b0;
    n_cmp++;
    if ({ok, done, sum} !== {2'b10, 16'h0000}) begin
      n_err++; $display("FAIL midrst_regrant got=%h want=%h", {ok, done, sum}, {2'b10, 16'h0000});
    end
    wait_for(2, ok);
    n_cmp++;
    if ({ok, sum, cout, ovf, done_id} !== {1'b1, 16'h0100, 3'b000}) begin
      n_err++; $display("FAIL midrst_result got=%h want=%h", {ok, sum, cout, ovf, done_id}, {1'b1, 16'h0100, 3'b000});
    end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1'b1;
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if ({sum, cout, ovf, p_all, g_all, done} !== {16'h0100, 5'b00000}) begin
      n_err++; $display("FAIL hold_idle got=%h want=%h", {sum, cout, ovf, p_all, g_all, done}, {16'h0100, 5'b00000});
    end
    a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0; req0 = 1'b1;
    wait_for(0, ok);
    req0 = 1'b0; a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ok, busy, sum} !== {2'b11, 16'h0100}) begin
      n_err++; $display("FAIL hold_during_run got=%h want=%h", {ok, busy, sum}, {2'b11, 16'h0100});
    end
    wait_for(2, ok);
    n_cmp++;
    if ({ok, sum, cout, ovf, done_id} !== {1'b1, 16'h3333, 3'b000}) begin
      n_err++; $display("FAIL hold_inflight got=%h want=%h", {ok, sum, cout, ovf, done_id}, {1'b1, 16'h3333, 3'b000});
    end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_req1_carry();
    test_tie();
    test_reset_mid_run();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
